// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field positions, MODE codes, FSM encodings and the byte-lane merge helper.
package timer_device_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESET   = 2'd1;
    localparam logic [1:0] ADDR_COUNT    = 2'd2;
    localparam logic [1:0] ADDR_PRESCALE = 2'd3;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timerState_t;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  be);
        logic [31:0] merged;
        merged = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = newVal[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_device_if.sv
// Bridge-side bus of the timer: address/data/byte-enables/strobe towards the
// device, combinational read data and interrupt back to the CPU side.
interface timer_device_if;
    logic [1:0]  device_addr;
    logic [31:0] device_din;
    logic [3:0]  device_BE;
    logic        we;
    logic [31:0] device_dout;
    logic        irq;

    modport master (
        output device_addr, device_din, device_BE, we,
        input  device_dout, irq
    );

    modport slave (
        input  device_addr, device_din, device_BE, we,
        output device_dout, irq
    );
endinterface

// File: rtl/timer_device_prescaler.sv
// Clock divider for the timer count enable. Only compiled when TIMER_PRESCALE_EN
// is defined; tick is high for one clock out of every prescale+1 while not cleared.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);
    logic [15:0] divCnt;

    // ">=" keeps the divider sane if PRESCALE is lowered below the running count.
    assign tick = !clear && (divCnt >= prescale);

    // Divider counter: restarts on clear and after every tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               divCnt <= '0;
        else if (clear || tick)  divCnt <= '0;
        else                     divCnt <= divCnt + 16'd1;
    end
endmodule
`endif

// File: rtl/timer_device.sv
// Programmable countdown timer behind the CPU bridge: CTRL/PRESET/COUNT/PRESCALE
// registers, IDLE->LOAD->CNT->INT sequencer, masked interrupt output.
// Optional feature macro: TIMER_PRESCALE_EN (adds PRESCALE register and divider;
// otherwise the count advances every clock in CNT and offset 3 reads 0).
module timer_device
    import timer_device_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    timer_device_if.slave  bus
);
    logic [CTRL_W-1:0] ctrlReg, ctrlNext;
    logic [CNT_W-1:0]  presetReg, presetNext;
    logic [CNT_W-1:0]  countReg, countNext;
    timerState_t       state, stateNext;
    logic              irqPending, irqPendingNext;
    logic              tick;
    logic              wrCtrl, wrPreset, expireEvent;
    logic [31:0]       presetMerged;
    logic [31:0]       prescaleRead;
    logic              ctrlEn;
    logic [1:0]        ctrlMode;

    assign wrCtrl       = bus.we && (bus.device_addr == ADDR_CTRL);
    assign wrPreset     = bus.we && (bus.device_addr == ADDR_PRESET);
    assign presetMerged = byteMerge(32'(presetReg), bus.device_din, bus.device_BE);
    assign ctrlEn       = ctrlReg[CTRL_EN_BIT];
    assign ctrlMode     = ctrlReg[CTRL_MODE_LSB +: 2];

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescaleReg;

    timer_prescaler uPrescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != ST_CNT),
        .prescale (prescaleReg),
        .tick     (tick)
    );

    assign prescaleRead = {16'd0, prescaleReg};

    // PRESCALE register: low two byte lanes writable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaleReg <= '0;
        end else if (bus.we && (bus.device_addr == ADDR_PRESCALE)) begin
            if (bus.device_BE[0]) prescaleReg[7:0]  <= bus.device_din[7:0];
            if (bus.device_BE[1]) prescaleReg[15:8] <= bus.device_din[15:8];
        end
    end
`else
    assign tick         = 1'b1;
    assign prescaleRead = 32'd0;
`endif

    // Sequencer and register next-state; CPU writes are applied last so they win.
    always_comb begin
        stateNext      = state;
        countNext      = countReg;
        irqPendingNext = irqPending;
        ctrlNext       = ctrlReg;
        presetNext     = presetReg;
        expireEvent    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ctrlEn) stateNext = ST_LOAD;
            end
            ST_LOAD: begin
                countNext = presetReg;
                stateNext = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrlEn) begin
                    stateNext = ST_IDLE;
                end else if (tick) begin
                    if (countReg != '0) begin
                        countNext = countReg - CNT_W'(1);
                    end else begin
                        stateNext      = ST_INT;
                        irqPendingNext = 1'b1;
                        expireEvent    = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (ctrlMode == MODE_RELOAD) begin
                    stateNext      = ST_LOAD;
                    irqPendingNext = 1'b0;
                end else begin
                    ctrlNext[CTRL_EN_BIT] = 1'b0;
                    stateNext             = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // A fresh expiry on the same edge is not swallowed by the acknowledge.
        if ((wrCtrl || wrPreset) && !expireEvent) irqPendingNext = 1'b0;
        if (wrCtrl && bus.device_BE[0]) ctrlNext = bus.device_din[CTRL_W-1:0];
        if (wrPreset) presetNext = presetMerged[CNT_W-1:0];
    end

    // State and register storage with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ctrlReg    <= '0;
            presetReg  <= '0;
            countReg   <= '0;
            irqPending <= 1'b0;
        end else begin
            state      <= stateNext;
            ctrlReg    <= ctrlNext;
            presetReg  <= presetNext;
            countReg   <= countNext;
            irqPending <= irqPendingNext;
        end
    end

    // Combinational read path for the CPU load.
    always_comb begin
        bus.device_dout = 32'd0;
        case (bus.device_addr)
            ADDR_CTRL:     bus.device_dout = 32'(ctrlReg);
            ADDR_PRESET:   bus.device_dout = 32'(presetReg);
            ADDR_COUNT:    bus.device_dout = 32'(countReg);
            ADDR_PRESCALE: bus.device_dout = prescaleRead;
            default:       bus.device_dout = 32'd0;
        endcase
    end

    assign bus.irq = irqPending & ctrlReg[CTRL_IM_BIT];

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: stimulus pushes expected read data and irq
// into a scoreboard queue; a monitor pops and compares when a check is presented.
module tb_timer_device;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chkReq = 1'b0;

    timer_device_if bus ();

    timer_device #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] expD;
        logic        expIrq;
    } expItem_t;

    expItem_t scb[$];
    int checks = 0;
    int passed = 0;

    // Auto-reload expectations, observed after edges E0..E13 of the enabling write.
    logic [31:0] reloadCnt [14] = '{0, 0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0, 0};
    logic        reloadIrq [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

    // Monitor: compare presented read data and irq against the oldest expectation.
    always @(negedge clk) begin
        expItem_t e;
        if (chkReq) begin
            if (scb.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_empty: check presented with no expectation queued");
            end else begin
                e = scb.pop_front();
                checks++;
                if (bus.device_dout === e.expD) passed++;
                else $display("FAIL %s dout: got %h, expected %h", e.name, bus.device_dout, e.expD);
                checks++;
                if (bus.irq === e.expIrq) passed++;
                else $display("FAIL %s irq: got %b, expected %b", e.name, bus.irq, e.expIrq);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.device_addr = a;
        bus.device_din  = d;
        bus.device_BE   = be;
        bus.we          = 1'b1;
        @(posedge clk);
        #1;
        bus.we        = 1'b0;
        bus.device_BE = 4'h0;
    endtask

    task automatic chk(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
        expItem_t e;
        e.name   = nm;
        e.expD   = d;
        e.expIrq = i;
        scb.push_back(e);
        bus.device_addr = a;
        chkReq = 1'b1;
        @(negedge clk);
        #1;
        chkReq = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.device_addr = 2'd0;
        bus.device_din  = 32'd0;
        bus.device_BE   = 4'h0;
        bus.we          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        chk(2'd0, 32'd0, 1'b0, "rst_ctrl");
        chk(2'd1, 32'd0, 1'b0, "rst_preset");
        chk(2'd2, 32'd0, 1'b0, "rst_count");
        chk(2'd3, 32'd0, 1'b0, "rst_prescale");

        // One-shot PRESET=5, irq after E8, EN cleared, ack by CTRL write
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        step(6);
        chk(2'd2, 32'd1, 1'b0, "os_cnt_e6");
        chk(2'd2, 32'd0, 1'b0, "os_cnt_e7");
        chk(2'd0, 32'h9, 1'b1, "os_irq_e8");
        chk(2'd0, 32'h8, 1'b1, "os_en_clr");
        chk(2'd2, 32'd0, 1'b1, "os_hold");
        wr(2'd0, 32'h0, 4'hF);
        chk(2'd0, 32'h0, 1'b0, "os_ack");
        wr(2'd0, 32'h8, 4'hF);
        chk(2'd0, 32'h8, 1'b0, "os_pend_clr");

        // Auto-reload PRESET=3
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        for (int k = 0; k < 14; k++) chk(2'd2, reloadCnt[k], reloadIrq[k], $sformatf("rl_e%0d", k));

        // PRESET rewrite mid-count only affects the next load
        step(1);
        wr(2'd1, 32'd100, 4'hF);
        chk(2'd2, 32'd1, 1'b0, "mid_cnt1");
        chk(2'd2, 32'd0, 1'b0, "mid_cnt0");
        chk(2'd2, 32'd0, 1'b1, "mid_irq");
        chk(2'd2, 32'd0, 1'b0, "mid_pulse_end");
        chk(2'd2, 32'd100, 1'b0, "mid_reload100");
        chk(2'd2, 32'd99, 1'b0, "mid_cnt99");
        wr(2'd0, 32'h0, 4'hF);
        chk(2'd2, 32'd97, 1'b0, "dis_last_dec");
        chk(2'd2, 32'd97, 1'b0, "dis_hold");
        wr(2'd0, 32'h1, 4'hF);
        chk(2'd2, 32'd97, 1'b0, "re_idle");
        chk(2'd2, 32'd97, 1'b0, "re_load");
        chk(2'd2, 32'd100, 1'b0, "re_loaded");
        wr(2'd0, 32'h0, 4'hF);
        chk(2'd2, 32'd98, 1'b0, "re_stop");
        chk(2'd2, 32'd98, 1'b0, "re_hold");

        // Byte enables, read-only COUNT, CTRL lane 0 and width
        wr(2'd1, 32'h0, 4'hF);
        wr(2'd1, 32'hFFFF_FFFF, 4'b0010);
        chk(2'd1, 32'h0000_FF00, 1'b0, "be_ff");
        wr(2'd1, 32'h0000_AB00, 4'b0010);
        chk(2'd1, 32'h0000_AB00, 1'b0, "be_ab");
        wr(2'd1, 32'h1234_5678, 4'b1001);
        chk(2'd1, 32'h1200_AB78, 1'b0, "be_1001");
        wr(2'd2, 32'h0000_DEAD, 4'hF);
        chk(2'd2, 32'd98, 1'b0, "count_ro");
        wr(2'd0, 32'hF, 4'b1110);
        chk(2'd0, 32'h0, 1'b0, "ctrl_be0");
        wr(2'd0, 32'hFFFF_FFF8, 4'hF);
        chk(2'd0, 32'h8, 1'b0, "ctrl_width");
        wr(2'd3, 32'hFFFF, 4'hF);
`ifdef TIMER_PRESCALE_EN
        chk(2'd3, 32'hFFFF, 1'b0, "prescale_rw");
        wr(2'd3, 32'h0, 4'hF);
`else
        chk(2'd3, 32'h0, 1'b0, "prescale_absent");
`endif

        // CPU CTRL write wins over the one-shot EN clear in INT
        wr(2'd1, 32'd0, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        step(2);
        chk(2'd0, 32'h9, 1'b0, "win_pre");
        wr(2'd0, 32'h9, 4'hF);
        chk(2'd0, 32'h9, 1'b0, "win_en_kept");
        chk(2'd0, 32'h9, 1'b0, "win_load");
        chk(2'd0, 32'h9, 1'b0, "win_cnt");
        chk(2'd0, 32'h9, 1'b1, "win_refire");
        chk(2'd0, 32'h8, 1'b1, "win_en_clr");

`ifdef TIMER_PRESCALE_EN
        // PRESCALE=3, PRESET=2: decrement every 4 clocks
        wr(2'd3, 32'd3, 4'hF);
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        for (int k = 0; k < 15; k++)
            chk(2'd2, (k < 2) ? 32'd0 : (k < 6) ? 32'd2 : (k < 10) ? 32'd1 : 32'd0,
                (k == 14), $sformatf("psc_e%0d", k));
        wr(2'd3, 32'd0, 4'hF);
        wr(2'd0, 32'h0, 4'hF);
`endif

        // Asynchronous reset in the middle of a count
        wr(2'd1, 32'd50, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        step(4);
        chk(2'd2, 32'd48, 1'b0, "ar_cnt");
        reset = 1'b1;
        chk(2'd2, 32'd0, 1'b0, "ar_count");
        chk(2'd1, 32'd0, 1'b0, "ar_preset");
        chk(2'd0, 32'd0, 1'b0, "ar_ctrl");
        reset = 1'b0;
        chk(2'd2, 32'd0, 1'b0, "ar_after");

        step(2);
        if (scb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", scb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
